// File: rtl/rlgl_game_sequencer_pkg.sv
// Shared types and constants for the red-light/green-light game sequencer.
package rlgl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHANT = 2'd1,
        WATCH = 2'd2,
        END   = 2'd3
    } state_e;

    localparam logic [1:0] COND_PLAY    = 2'd0;
    localparam logic [1:0] COND_SURVIVE = 2'd1;
    localparam logic [1:0] COND_DIE     = 2'd2;

    localparam logic [2:0] PIC_DIE   = 3'd0;
    localparam logic [2:0] PIC_LEFT  = 3'd1;
    localparam logic [2:0] PIC_MID   = 3'd2;
    localparam logic [2:0] PIC_RIGHT = 3'd3;
    localparam logic [2:0] PIC_MID2  = 3'd4;

    // Walk cycle left, mid, right, mid; anything unexpected restarts at left.
    function automatic logic [2:0] next_pic(input logic [2:0] pic);
        case (pic)
            PIC_LEFT:  return PIC_MID;
            PIC_MID:   return PIC_RIGHT;
            PIC_RIGHT: return PIC_MID2;
            default:   return PIC_LEFT;
        endcase
    endfunction

    // x^4 + x^3 + 1 Fibonacci LFSR, shifting towards the MSB.
    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

endpackage

// File: rtl/rlgl_game_sequencer_if.sv
// Button-pulse inputs and renderer status outputs of the game sequencer.
interface rlgl_game_sequencer_if;
    logic       start;
    logic       p1_step;
    logic       p2_step;
    logic       black;
    logic       minute;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [3:0] remain1;
    logic [3:0] remain0;
    logic [4:0] p1_pos;
    logic [4:0] p2_pos;
    logic [2:0] p1_pic;
    logic [2:0] p2_pic;
    logic [1:0] p1_cond;
    logic [1:0] p2_cond;
    logic       doll_watch;

    // Button side: drives pulses, watches status.
    modport master (
        output start, p1_step, p2_step,
        input  black, minute, sec1, sec0, remain1, remain0,
        input  p1_pos, p2_pos, p1_pic, p2_pic, p1_cond, p2_cond, doll_watch
    );

    // Sequencer side.
    modport slave (
        input  start, p1_step, p2_step,
        output black, minute, sec1, sec0, remain1, remain0,
        output p1_pos, p2_pos, p1_pic, p2_pic, p1_cond, p2_cond, doll_watch
    );
endinterface

// File: rtl/rlgl_game_sequencer_bcd_down_counter.sv
// Multi-digit BCD down-counter: load, decrement, saturates at all-zero.
// Digit 1 wraps to TENS_MAX on borrow (5 for seconds tens), others wrap to 9.
module bcd_down_counter #(
    parameter int                    DIGITS   = 2,
    parameter int                    TENS_MAX = 9,
    parameter logic [DIGITS*4-1:0]   RST_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [DIGITS-1:0][3:0]  load_val_i,
    input  logic                    dec_i,
    output logic [DIGITS-1:0][3:0]  cnt_o,
    output logic                    zero_o
);

    logic [DIGITS-1:0][3:0] cnt_q, cnt_d;

    assign zero_o = (cnt_q == '0);
    assign cnt_o  = cnt_q;

    // Ripple a borrow up from the units digit; load wins over decrement.
    always_comb begin
        logic borrow;
        cnt_d  = cnt_q;
        borrow = dec_i & ~zero_o;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (cnt_q[i] == 4'd0) begin
                    cnt_d[i] = (i == 1) ? 4'(TENS_MAX) : 4'd9;
                end else begin
                    cnt_d[i] = cnt_q[i] - 4'd1;
                    borrow   = 1'b0;
                end
            end
        end
        if (load_i) cnt_d = load_val_i;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= RST_VAL;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rlgl_game_sequencer.sv
// Red-light/green-light game controller: phase sequencing, game clock,
// rounds counter and per-player position/animation/status.
module rlgl_game_sequencer
    import rlgl_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int GAME_SEC    = 90,
    parameter int ROUNDS      = 12,
    parameter int GOAL_POS    = 30,
    parameter int CHANT_MIN_S = 2,
    parameter int WATCH_S     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    rlgl_game_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_CHANT = CHANT;
    localparam logic [1:0] S_WATCH = WATCH;
    localparam logic [1:0] S_END   = END;

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    // Initial m:ss and rounds, as BCD digits.
    localparam logic [11:0] CLK_INIT = {4'(GAME_SEC / 60), 4'((GAME_SEC % 60) / 10),
                                        4'(GAME_SEC % 10)};
    localparam logic [7:0]  REM_INIT = {4'(ROUNDS / 10), 4'(ROUNDS % 10)};

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      phase_q, phase_d;
    logic [3:0]      lfsr_q, lfsr_d;
    logic [1:0][4:0] pos_q, pos_d;
    logic [1:0][2:0] pic_q, pic_d;
    logic [1:0][1:0] cond_q, cond_d;
    logic            black_q, black_d;
    logic            watch_q, watch_d;

    logic            running, tick, expire;
    logic            game_load, rem_dec, enter_chant;
    logic [1:0]      step;
    logic [2:0][3:0] clk_cnt;
    logic [1:0][3:0] rem_cnt;
    logic            clk_zero, rem_zero;

    assign step    = {bus.p2_step, bus.p1_step};
    assign running = (state_q == S_CHANT) || (state_q == S_WATCH);
    assign tick    = running && (presc_q == PW'(CLK_HZ - 1));
    assign expire  = tick && (phase_q <= 8'd1);

    bcd_down_counter #(.DIGITS(3), .TENS_MAX(5), .RST_VAL(CLK_INIT)) u_clock (
        .clk(clk), .rst(rst), .load_i(game_load), .load_val_i(CLK_INIT),
        .dec_i(tick), .cnt_o(clk_cnt), .zero_o(clk_zero)
    );

    bcd_down_counter #(.DIGITS(2), .TENS_MAX(9), .RST_VAL(REM_INIT)) u_remain (
        .clk(clk), .rst(rst), .load_i(game_load), .load_val_i(REM_INIT),
        .dec_i(rem_dec), .cnt_o(rem_cnt), .zero_o(rem_zero)
    );

    // Steps are judged by the current state; then the phase/timeout transition.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        lfsr_d      = lfsr_q;
        pos_d       = pos_q;
        pic_d       = pic_q;
        cond_d      = cond_q;
        game_load   = 1'b0;
        rem_dec     = 1'b0;
        enter_chant = 1'b0;

        for (int p = 0; p < 2; p++) begin
            if (step[p] && cond_q[p] == COND_PLAY) begin
                if (state_q == S_CHANT) begin
                    pos_d[p] = pos_q[p] + 5'd1;
                    pic_d[p] = next_pic(pic_q[p]);
                    if (pos_q[p] + 5'd1 == 5'(GOAL_POS)) cond_d[p] = COND_SURVIVE;
                end else if (state_q == S_WATCH) begin
                    cond_d[p] = COND_DIE;
                    pic_d[p]  = PIC_DIE;
                end
            end
        end

        case (state_q)
            S_IDLE, S_END: begin
                if (bus.start) begin
                    game_load   = 1'b1;
                    enter_chant = 1'b1;
                    pos_d       = '0;
                    pic_d       = {PIC_MID, PIC_MID};
                    cond_d      = '0;
                end
            end
            default: begin
                if (tick) phase_d = phase_q - 8'd1;
                if (clk_zero || (cond_q[0] != COND_PLAY && cond_q[1] != COND_PLAY)) begin
                    state_d = S_END;
                end else if (expire) begin
                    if (state_q == S_CHANT) begin
                        state_d = S_WATCH;
                        phase_d = 8'(WATCH_S);
                        rem_dec = 1'b1;
                    end else if (!rem_zero) begin
                        enter_chant = 1'b1;
                    end else begin
                        state_d = S_END;
                    end
                end
            end
        endcase

        if (enter_chant) begin
            state_d = S_CHANT;
            phase_d = 8'(CHANT_MIN_S) + 8'(lfsr_q[1:0]);
            lfsr_d  = lfsr_next(lfsr_q);
        end

        // Anyone still playing when the game ends is caught.
        if (state_d == S_END && state_q != S_END) begin
            for (int p = 0; p < 2; p++) begin
                if (cond_d[p] == COND_PLAY) begin
                    cond_d[p] = COND_DIE;
                    pic_d[p]  = PIC_DIE;
                end
            end
        end
    end

    // 1 s prescaler: runs only while a phase is active, restarts on every state entry.
    always_comb begin
        if (state_d != state_q || tick || !running) presc_d = '0;
        else                                        presc_d = presc_q + PW'(1);
    end

    assign black_d = (state_d == S_IDLE);
    assign watch_d = (state_d == S_WATCH);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            phase_q <= '0;
            lfsr_q  <= 4'b1001;
            pos_q   <= '0;
            pic_q   <= {PIC_MID, PIC_MID};
            cond_q  <= '0;
            black_q <= 1'b1;
            watch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            lfsr_q  <= lfsr_d;
            pos_q   <= pos_d;
            pic_q   <= pic_d;
            cond_q  <= cond_d;
            black_q <= black_d;
            watch_q <= watch_d;
        end
    end

    // Minutes digit never exceeds 1, so any set bit means one minute.
    assign bus.black      = black_q;
    assign bus.minute     = |clk_cnt[2];
    assign bus.sec1       = clk_cnt[1];
    assign bus.sec0       = clk_cnt[0];
    assign bus.remain1    = rem_cnt[1];
    assign bus.remain0    = rem_cnt[0];
    assign bus.p1_pos     = pos_q[0];
    assign bus.p2_pos     = pos_q[1];
    assign bus.p1_pic     = pic_q[0];
    assign bus.p2_pic     = pic_q[1];
    assign bus.p1_cond    = cond_q[0];
    assign bus.p2_cond    = cond_q[1];
    assign bus.doll_watch = watch_q;

endmodule

// File: tb/tb_rlgl_game_sequencer.sv
// Bench for rlgl_game_sequencer: directed opening plus random games,
// every cycle compared against a seconds/cycles-level game model.
module tb_rlgl_game_sequencer;

    localparam int HZ = 4, GS = 20, RN = 3, GP = 4, CM = 2, WS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rlgl_game_sequencer_if bus();

    rlgl_game_sequencer #(
        .CLK_HZ(HZ), .GAME_SEC(GS), .ROUNDS(RN), .GOAL_POS(GP),
        .CHANT_MIN_S(CM), .WATCH_S(WS)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    endtask

    // ---------------- behavioural model ----------------
    // st: 0 idle, 1 chant, 2 watch, 3 end. Time kept as whole seconds left
    // plus cycles spent in the current phase.
    int m_st, m_clk, m_rem, m_lfsr, m_cyc, m_plen;
    int m_pos[2], m_pic[2], m_cond[2];

    function automatic void go_chant();
        m_plen = (CM + (m_lfsr % 4)) * HZ;
        m_lfsr = ((m_lfsr * 2) % 16) + (((m_lfsr / 8) + (m_lfsr / 4)) % 2);
        m_st   = 1;
        m_cyc  = 0;
    endfunction

    function automatic void go_end();
        m_st = 3;
        for (int p = 0; p < 2; p++)
            if (m_cond[p] == 0) begin m_cond[p] = 2; m_pic[p] = 0; end
    endfunction

    always @(posedge clk) begin
        int  stp[2];
        bit  tk, ex, fin;
        stp[0] = int'(bus.p1_step);
        stp[1] = int'(bus.p2_step);
        if (rst) begin
            m_st = 0; m_clk = GS; m_rem = RN; m_lfsr = 9; m_cyc = 0; m_plen = 0;
            for (int p = 0; p < 2; p++) begin m_pos[p] = 0; m_pic[p] = 2; m_cond[p] = 0; end
        end else if (m_st == 0 || m_st == 3) begin
            if (bus.start) begin
                m_clk = GS; m_rem = RN;
                for (int p = 0; p < 2; p++) begin m_pos[p] = 0; m_pic[p] = 2; m_cond[p] = 0; end
                go_chant();
            end
        end else begin
            tk  = ((m_cyc + 1) % HZ) == 0;
            ex  = (m_cyc + 1) == m_plen;
            fin = (m_clk == 0) || (m_cond[0] != 0 && m_cond[1] != 0);
            for (int p = 0; p < 2; p++) begin
                if (stp[p] != 0 && m_cond[p] == 0) begin
                    if (m_st == 1) begin
                        m_pos[p] = m_pos[p] + 1;
                        m_pic[p] = (m_pic[p] >= 1 && m_pic[p] <= 3) ? m_pic[p] + 1 : 1;
                        if (m_pos[p] == GP) m_cond[p] = 1;
                    end else begin
                        m_cond[p] = 2;
                        m_pic[p]  = 0;
                    end
                end
            end
            if (tk && m_clk > 0) m_clk = m_clk - 1;
            m_cyc = m_cyc + 1;
            if (fin) go_end();
            else if (ex) begin
                if (m_st == 1) begin
                    m_rem  = (m_rem > 0) ? m_rem - 1 : 0;
                    m_st   = 2;
                    m_cyc  = 0;
                    m_plen = WS * HZ;
                end else if (m_rem != 0) go_chant();
                else go_end();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [38:0] got_v, exp_v;
        if (chk_en) begin
            got_v = {bus.black, bus.minute, bus.sec1, bus.sec0, bus.remain1, bus.remain0,
                     bus.p1_pos, bus.p2_pos, bus.p1_pic, bus.p2_pic,
                     bus.p1_cond, bus.p2_cond, bus.doll_watch};
            exp_v = {1'(m_st == 0), 1'(m_clk / 60), 4'((m_clk % 60) / 10), 4'(m_clk % 10),
                     4'(m_rem / 10), 4'(m_rem % 10), 5'(m_pos[0]), 5'(m_pos[1]),
                     3'(m_pic[0]), 3'(m_pic[1]), 2'(m_cond[0]), 2'(m_cond[1]), 1'(m_st == 2)};
            check("outputs", 64'(got_v), 64'(exp_v));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit s, input bit a, input bit b);
        @(negedge clk);
        #1;
        rst = r; bus.start = s; bus.p1_step = a; bus.p2_step = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start = 1'b0; bus.p1_step = 1'b0; bus.p2_step = 1'b0;
        drive(1, 0, 0, 0);
        chk_en = 1'b1;
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("rst_black", bus.black, 1);
        check("rst_clock", {bus.minute, bus.sec1, bus.sec0}, 9'h020);
        check("rst_remain", {bus.remain1, bus.remain0}, 8'h03);
        check("rst_players", {bus.p1_pos, bus.p2_pos, bus.p1_pic, bus.p2_pic,
                              bus.p1_cond, bus.p2_cond, bus.doll_watch},
              {5'd0, 5'd0, 3'd2, 3'd2, 2'd0, 2'd0, 1'b0});

        drive(0, 1, 0, 0);                        // edge E0: enter CHANT (3 s)
        check("start_black", bus.black, 0);
        drive(0, 0, 1, 0); check("pic_step1", bus.p1_pic, 3);
        drive(0, 0, 1, 0); check("pic_step2", bus.p1_pic, 4);
        drive(0, 0, 1, 0); check("pic_step3", bus.p1_pic, 1);
        check("pos_step3", {bus.p1_pos, bus.p1_cond}, {5'd3, 2'd0});
        drive(0, 0, 0, 0);                        // E4: first tick
        check("clock_tick1", {bus.minute, bus.sec1, bus.sec0}, 9'h019);
        repeat (7) drive(0, 0, 0, 0);             // E11
        check("chant_still", bus.doll_watch, 0);
        drive(0, 0, 0, 0);                        // E12: CHANT -> WATCH
        check("watch_rise", bus.doll_watch, 1);
        check("remain_dec", {bus.remain1, bus.remain0}, 8'h02);
        drive(0, 0, 0, 1);
        check("p2_caught", {bus.p2_pos, bus.p2_pic, bus.p2_cond}, {5'd0, 3'd0, 2'd2});
        drive(0, 0, 0, 1);
        check("p2_ignored", {bus.p2_pos, bus.p2_pic, bus.p2_cond}, {5'd0, 3'd0, 2'd2});
        drive(1, 0, 0, 0);                        // reset mid-WATCH
        check("midrst_state", {bus.black, bus.doll_watch, bus.minute, bus.sec1, bus.sec0},
              {1'b1, 1'b0, 9'h020});
        check("midrst_players", {bus.p1_pos, bus.p2_pos, bus.p1_cond, bus.p2_cond}, 14'd0);
        drive(0, 0, 0, 0);

        for (int g = 0; g < 30; g++) begin
            int budget, crate, wrate;
            crate  = $urandom_range(2, 8);
            wrate  = $urandom_range(15, 60);
            budget = 0;
            drive(0, 1, 0, 0);
            while (m_st != 3 && m_st != 0 && budget < 400) begin
                if (bus.doll_watch)
                    drive($urandom_range(0, 499) == 0, $urandom_range(0, 49) == 0,
                          $urandom_range(0, wrate - 1) == 0, $urandom_range(0, wrate - 1) == 0);
                else
                    drive($urandom_range(0, 499) == 0, $urandom_range(0, 49) == 0,
                          $urandom_range(0, crate - 1) == 0, $urandom_range(0, crate - 1) == 0);
                budget++;
            end
            if (budget >= 400) check("game_end_timeout", 64'(budget), 0);
            repeat (3) drive(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        drive(0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
